// File: rtl/batch_mul_pkg.sv
// Shared definitions for the batch multiply engine: register map, bank
// regions, status/mode bit positions and FSM state encodings.
package batch_mul_pkg;

  localparam logic [7:0] OFF_OPSTART = 8'h00;
  localparam logic [7:0] OFF_INTR_EN = 8'h01;
  localparam logic [7:0] OFF_COUNT   = 8'h02;
  localparam logic [7:0] OFF_MODE    = 8'h03;
  localparam logic [7:0] OFF_STATUS  = 8'h04;
  localparam logic [7:0] OFF_CLEAR   = 8'h05;

  // s_addr[7:6] selects the window: control registers or one of the banks.
  localparam logic [1:0] REGION_CTRL = 2'b00;
  localparam logic [1:0] REGION_A    = 2'b01;
  localparam logic [1:0] REGION_B    = 2'b10;
  localparam logic [1:0] REGION_R    = 2'b11;

  localparam int MODE_SIGNED_BIT = 0;
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MUL   = 3'd2,
    ST_STORE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/mul_seq.sv
// Sequential radix-2 shift-add multiplier: one partial product per cycle on
// operand magnitudes, with the sign applied to the finished product.
module mul_seq #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_i,
  input  logic                  signed_mode_i,
  input  logic [DATA_W-1:0]     a_i,
  input  logic [DATA_W-1:0]     b_i,
  output logic                  busy_o,
  output logic                  last_o,
  output logic [2*DATA_W-1:0]   product_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic                neg_q, neg_d;
  logic                a_neg_s, b_neg_s;
  logic [DATA_W-1:0]   a_mag_s, b_mag_s;
  logic [DATA_W:0]     sum_s;

  // Operand magnitudes, the add step and next-state of the shift register.
  always_comb begin
    a_neg_s = signed_mode_i & a_i[DATA_W-1];
    b_neg_s = signed_mode_i & b_i[DATA_W-1];
    a_mag_s = a_neg_s ? (~a_i + DATA_W'(1)) : a_i;
    b_mag_s = b_neg_s ? (~b_i + DATA_W'(1)) : b_i;
    sum_s   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} +
              {1'b0, (acc_q[0] ? mcand_q : {DATA_W{1'b0}})};
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    if (start_i) begin
      cnt_d   = CNT_W'(DATA_W);
      mcand_d = a_mag_s;
      acc_d   = {{DATA_W{1'b0}}, b_mag_s};
      neg_d   = a_neg_s ^ b_neg_s;
    end else if (cnt_q != {CNT_W{1'b0}}) begin
      acc_d = {sum_s, acc_q[DATA_W-1:1]};
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      acc_d = acc_q;
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q   <= {CNT_W{1'b0}};
      mcand_q <= {DATA_W{1'b0}};
      acc_q   <= {(2*DATA_W){1'b0}};
      neg_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
    end
  end

  assign busy_o    = (cnt_q != {CNT_W{1'b0}});
  assign last_o    = (cnt_q == CNT_W'(1));
  assign product_o = neg_q ? (~acc_q + (2*DATA_W)'(1)) : acc_q;

endmodule

// File: rtl/batch_mul_engine.sv
// Bus-mapped batch multiplier: runs A[i]*B[i] -> R[i] over COUNT entries
// using one shared sequential multiplier, with done status and interrupt.
module batch_mul_engine
  import batch_mul_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                s_sel,
  input  logic                s_wr,
  input  logic [7:0]          s_addr,
  input  logic [DATA_W-1:0]   s_din,
  output logic [2*DATA_W-1:0] s_dout,
  output logic                interrupt
);

  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [6:0]        DEPTH_L   = 7'(DEPTH);
  localparam logic [DATA_W-1:0] DEPTH_CNT = DATA_W'(DEPTH);

  logic [DATA_W-1:0]   a_mem [DEPTH];
  logic [DATA_W-1:0]   b_mem [DEPTH];
  logic [2*DATA_W-1:0] r_mem [DEPTH];

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                done_q, done_d;
  logic                intr_en_q, intr_en_d;
  logic                mode_q, mode_d;
  logic [DATA_W-1:0]   count_q, count_d;
  logic                interrupt_q;

  logic                wr_s, rd_s, busy_s, cfg_wr_ok_s, start_s, clear_s;
  logic [1:0]          region_s;
  logic                in_bank_s;
  logic [IDX_W-1:0]    bank_idx_s;
  logic [6:0]          eff_cnt_s;
  logic                last_elem_s;
  logic                mul_busy_s, mul_last_s;
  logic [2*DATA_W-1:0] mul_product_s;

  assign wr_s        = s_sel & s_wr;
  assign rd_s        = s_sel & ~s_wr;
  assign region_s    = s_addr[7:6];
  assign in_bank_s   = ({1'b0, s_addr[5:0]} < DEPTH_L);
  assign bank_idx_s  = s_addr[IDX_W-1:0];
  assign busy_s      = (state_q == ST_LOAD) || (state_q == ST_MUL) ||
                       (state_q == ST_STORE) || mul_busy_s;
  assign cfg_wr_ok_s = wr_s & ~busy_s;
  assign start_s     = wr_s && (s_addr == OFF_OPSTART) && s_din[0];
  assign clear_s     = wr_s && (s_addr == OFF_CLEAR) && s_din[0];
  // COUNT beyond the bank size is clamped so a run never walks off the banks.
  assign eff_cnt_s   = (count_q > DEPTH_CNT) ? DEPTH_L : count_q[6:0];
  assign last_elem_s = ((7'(idx_q) + 7'd1) == eff_cnt_s);

  mul_seq #(.DATA_W(DATA_W)) u_mul (
    .clk           (clk),
    .reset_n       (reset_n),
    .start_i       (state_q == ST_LOAD),
    .signed_mode_i (mode_q),
    .a_i           (a_mem[idx_q]),
    .b_i           (b_mem[idx_q]),
    .busy_o        (mul_busy_s),
    .last_o        (mul_last_s),
    .product_o     (mul_product_s)
  );

  // Control register updates and run sequencing.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    done_d    = done_q;
    intr_en_d = intr_en_q;
    count_d   = count_q;
    mode_d    = mode_q;
    if (wr_s && (s_addr == OFF_INTR_EN)) begin
      intr_en_d = s_din[0];
    end else begin
      intr_en_d = intr_en_q;
    end
    if (cfg_wr_ok_s && (s_addr == OFF_COUNT)) begin
      count_d = s_din;
    end else begin
      count_d = count_q;
    end
    if (cfg_wr_ok_s && (s_addr == OFF_MODE)) begin
      mode_d = s_din[MODE_SIGNED_BIT];
    end else begin
      mode_d = mode_q;
    end
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_s) begin
          done_d  = 1'b0;
          idx_d   = {IDX_W{1'b0}};
          state_d = (count_q == {DATA_W{1'b0}}) ? ST_DONE : ST_LOAD;
        end else if (clear_s) begin
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          // done trails entry into DONE by one cycle
          done_d = (state_q == ST_DONE);
        end
      end
      ST_LOAD: begin
        state_d = ST_MUL;
      end
      ST_MUL: begin
        if (mul_last_s) begin
          state_d = ST_STORE;
        end else begin
          state_d = ST_MUL;
        end
      end
      ST_STORE: begin
        if (last_elem_s) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = {IDX_W{1'b0}};
        done_d  = 1'b0;
      end
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= {IDX_W{1'b0}};
      done_q      <= 1'b0;
      intr_en_q   <= 1'b0;
      count_q     <= {DATA_W{1'b0}};
      mode_q      <= 1'b0;
      interrupt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      done_q      <= done_d;
      intr_en_q   <= intr_en_d;
      count_q     <= count_d;
      mode_q      <= mode_d;
      interrupt_q <= done_d & intr_en_d;
    end
  end

  // Operand and result banks; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (reset_n && cfg_wr_ok_s && in_bank_s && (region_s == REGION_A)) begin
      a_mem[bank_idx_s] <= s_din;
    end
    if (reset_n && cfg_wr_ok_s && in_bank_s && (region_s == REGION_B)) begin
      b_mem[bank_idx_s] <= s_din;
    end
    if (reset_n && (state_q == ST_STORE)) begin
      r_mem[idx_q] <= mul_product_s;
    end
  end

  // Combinational read mux.
  always_comb begin
    s_dout = {(2*DATA_W){1'b0}};
    if (rd_s) begin
      case (region_s)
        REGION_CTRL: begin
          case (s_addr)
            OFF_INTR_EN: s_dout = (2*DATA_W)'(intr_en_q);
            OFF_COUNT:   s_dout = (2*DATA_W)'(count_q);
            OFF_MODE:    s_dout = (2*DATA_W)'(mode_q);
            OFF_STATUS:  s_dout = (2*DATA_W)'({done_q, busy_s});
            default:     s_dout = {(2*DATA_W){1'b0}};
          endcase
        end
        REGION_A: s_dout = in_bank_s ? (2*DATA_W)'(a_mem[bank_idx_s]) : {(2*DATA_W){1'b0}};
        REGION_B: s_dout = in_bank_s ? (2*DATA_W)'(b_mem[bank_idx_s]) : {(2*DATA_W){1'b0}};
        REGION_R: s_dout = in_bank_s ? r_mem[bank_idx_s] : {(2*DATA_W){1'b0}};
        default:  s_dout = {(2*DATA_W){1'b0}};
      endcase
    end else begin
      s_dout = {(2*DATA_W){1'b0}};
    end
  end

  assign interrupt = interrupt_q;

endmodule

// File: tb/tb_batch_mul_engine.sv
// Self-checking bench for batch_mul_engine: vector table, scoreboard of
// expected products, and directed multi-cycle corner cases.
module tb_batch_mul_engine;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s_sel;
  logic        s_wr;
  logic [7:0]  s_addr;
  logic [31:0] s_din;
  logic [63:0] s_dout;
  logic        interrupt;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic [63:0] sb[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sm;
    logic [63:0] exp;
  } vec_t;

  batch_mul_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_sel     (s_sel),
    .s_wr      (s_wr),
    .s_addr    (s_addr),
    .s_din     (s_din),
    .s_dout    (s_dout),
    .interrupt (interrupt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sm);
    logic [63:0] ea, eb;
    ea = sm ? {{32{a[31]}}, a} : {32'h0, a};
    eb = sm ? {{32{b[31]}}, b} : {32'h0, b};
    return ea * eb;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [31:0] data);
    s_sel = 1'b1; s_wr = 1'b1; s_addr = addr; s_din = data;
    @(posedge clk); #1;
    s_sel = 1'b0; s_wr = 1'b0; s_addr = 8'h00; s_din = 32'h0;
  endtask

  task automatic bus_read(input logic [7:0] addr, output logic [63:0] data);
    s_sel = 1'b1; s_wr = 1'b0; s_addr = addr;
    #1;
    data = s_dout;
    s_sel = 1'b0; s_addr = 8'h00;
    #1;
  endtask

  task automatic wait_done(input int limit);
    logic [63:0] st;
    int n;
    n = 0;
    bus_read(8'h04, st);
    while (st[1] !== 1'b1 && n < limit) begin
      @(posedge clk); #1;
      n++;
      bus_read(8'h04, st);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    vec_t        vecs[9];
    logic [63:0] rd;
    logic [63:0] saved[3];
    logic [31:0] a, b;
    int unsigned t0;
    int          n;

    vecs[0] = '{32'h00000003, 32'h00000005, 1'b0, 64'h000000000000000F};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};
    vecs[2] = '{32'hFFFFFFFE, 32'h00000003, 1'b1, 64'hFFFFFFFFFFFFFFFA};
    vecs[3] = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001};
    vecs[5] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC000000080000000};
    vecs[6] = '{32'h80000000, 32'h00000002, 1'b0, 64'h0000000100000000};
    vecs[7] = '{32'h00000000, 32'h12345678, 1'b1, 64'h0000000000000000};
    vecs[8] = '{32'hFFFFFFFB, 32'h00000007, 1'b1, 64'hFFFFFFFFFFFFFFDD};

    reset_n = 1'b0; s_sel = 1'b0; s_wr = 1'b0; s_addr = 8'h00; s_din = 32'h0;
    cycles(3);
    check("rst_interrupt", 64'(interrupt), 64'h0);
    check("rst_dout_idle", s_dout, 64'h0);
    reset_n = 1'b1;
    cycles(1);
    bus_read(8'h04, rd); check("rst_status", rd, 64'h0);
    bus_read(8'h01, rd); check("rst_intr_en", rd, 64'h0);
    bus_read(8'h02, rd); check("rst_count", rd, 64'h0);
    bus_read(8'h03, rd); check("rst_mode", rd, 64'h0);

    // Table: one single-element run per vector.
    for (int i = 0; i < 9; i++) begin
      bus_write(8'h03, {31'h0, vecs[i].sm});
      bus_write(8'h40, vecs[i].a);
      bus_write(8'h80, vecs[i].b);
      bus_write(8'h02, 32'd1);
      sb.push_back(vecs[i].exp);
      bus_write(8'h00, 32'd1);
      t0 = cyc;
      wait_done(100);
      check($sformatf("vec%0d_latency", i), 64'(cyc - t0), 64'd35);
      bus_read(8'hC0, rd);
      check($sformatf("vec%0d_result", i), rd, sb.pop_front());
    end

    // COUNT=10 with interrupt.
    bus_write(8'h05, 32'd1);
    bus_write(8'h01, 32'd1);
    bus_write(8'h03, 32'd0);
    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = $urandom;
      bus_write(8'h40 + 8'(i), a);
      bus_write(8'h80 + 8'(i), b);
      sb.push_back(model(a, b, 1'b0));
    end
    bus_write(8'h02, 32'd10);
    bus_write(8'h00, 32'd1);
    n = 0;
    while (interrupt !== 1'b1 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("irq_latency", 64'(n), 64'd341);
    for (int i = 0; i < 10; i++) begin
      bus_read(8'hC0 + 8'(i), rd);
      check($sformatf("batch10_r%0d", i), rd, sb.pop_front());
    end
    check("irq_before_clear", 64'(interrupt), 64'h1);
    bus_write(8'h05, 32'd1);
    check("irq_after_clear", 64'(interrupt), 64'h0);
    bus_read(8'h04, rd); check("status_after_clear", rd, 64'h0);

    // Mid-run B write and second OPSTART must be ignored.
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom;
      bus_write(8'h40 + 8'(i), a);
      bus_write(8'h80 + 8'(i), b);
      saved[i] = model(a, b, 1'b0);
      sb.push_back(saved[i]);
    end
    bus_read(8'h80, rd);
    a = rd[31:0];
    bus_write(8'h02, 32'd3);
    bus_write(8'h00, 32'd1);
    t0 = cyc;
    cycles(5);
    bus_read(8'h04, rd); check("midrun_busy", rd, 64'h1);
    bus_write(8'h80, 32'hDEADBEEF);
    bus_write(8'h00, 32'd1);
    wait_done(300);
    check("midrun_latency", 64'(cyc - t0), 64'd103);
    bus_read(8'h80, rd); check("midrun_b0_kept", rd, 64'(a));
    for (int i = 0; i < 3; i++) begin
      bus_read(8'hC0 + 8'(i), rd);
      check($sformatf("midrun_r%0d", i), rd, sb.pop_front());
    end

    // COUNT=0: immediate done, results untouched.
    bus_write(8'h02, 32'd0);
    bus_write(8'h00, 32'd1);
    t0 = cyc;
    wait_done(20);
    check("count0_latency", 64'(cyc - t0), 64'd1);
    for (int i = 0; i < 3; i++) begin
      bus_read(8'hC0 + 8'(i), rd);
      check($sformatf("count0_r%0d", i), rd, saved[i]);
    end

    // Reset in the middle of the multiply.
    bus_write(8'h03, 32'd1);
    bus_write(8'h40, 32'h11111111);
    bus_write(8'h80, 32'hFFFFFFF0);
    bus_write(8'h02, 32'd1);
    bus_write(8'h00, 32'd1);
    cycles(10);
    reset_n = 1'b0;
    cycles(1);
    check("abort_interrupt", 64'(interrupt), 64'h0);
    check("abort_dout_idle", s_dout, 64'h0);
    reset_n = 1'b1;
    bus_read(8'h04, rd); check("abort_status", rd, 64'h0);
    bus_read(8'h01, rd); check("abort_intr_en", rd, 64'h0);
    bus_read(8'h02, rd); check("abort_count", rd, 64'h0);
    bus_read(8'h03, rd); check("abort_mode", rd, 64'h0);
    cycles(40);
    bus_read(8'h04, rd); check("abort_no_done", rd, 64'h0);
    bus_read(8'hC0, rd); check("abort_r0_kept", rd, saved[0]);
    bus_read(8'h40, rd); check("abort_a0_kept", rd, 64'h11111111);
    bus_write(8'h03, 32'd1);
    bus_write(8'h02, 32'd1);
    sb.push_back(model(32'h11111111, 32'hFFFFFFF0, 1'b1));
    bus_write(8'h00, 32'd1);
    t0 = cyc;
    wait_done(100);
    check("rerun_latency", 64'(cyc - t0), 64'd35);
    bus_read(8'hC0, rd); check("rerun_r0", rd, sb.pop_front());

    // COUNT above DEPTH is clamped.
    bus_write(8'h03, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      a = $urandom; b = $urandom;
      bus_write(8'h40 + 8'(i), a);
      bus_write(8'h80 + 8'(i), b);
      sb.push_back(model(a, b, 1'b0));
    end
    bus_write(8'h02, 32'd200);
    bus_read(8'h02, rd); check("count200_readback", rd, 64'd200);
    bus_write(8'h00, 32'd1);
    t0 = cyc;
    wait_done(1000);
    check("count200_latency", 64'(cyc - t0), 64'd545);
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(8'hC0 + 8'(i), rd);
      check($sformatf("count200_r%0d", i), rd, sb.pop_front());
    end
    bus_read(8'hC0 + 8'(DEPTH), rd); check("r_out_of_range", rd, 64'h0);
    bus_read(8'h40 + 8'(DEPTH), rd); check("a_out_of_range", rd, 64'h0);
    bus_read(8'h06, rd); check("unmapped_read", rd, 64'h0);
    check("scoreboard_empty", 64'(sb.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
